// File: rtl/fp_mult_arbiter.sv
// Two-requester front end for a shared single-precision multiplier datapath.
// Round-robin grant, one operation in flight, timeout-guarded wait, valid/ready response.
module fp_mult_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [2:0]  rnd0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [2:0]  rnd1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_z,
    output logic [7:0]  resp_status,
    output logic        resp_timeout,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [2:0]  mul_rnd,
    input  logic        mul_done,
    input  logic [31:0] mul_z,
    input  logic [7:0]  mul_status,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic [CW-1:0] count;
    logic          win;
    logic          win_valid;

    // Under contention the requester that was not served last wins.
    always_comb begin
        win       = 1'b0;
        win_valid = 1'b0;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   begin win = 1'b0;        win_valid = 1'b1; end
                2'b10:   begin win = 1'b1;        win_valid = 1'b1; end
                2'b11:   begin win = ~last_grant; win_valid = 1'b1; end
                default: begin win = 1'b0;        win_valid = 1'b0; end
            endcase
        end
    end

    assign req_ready = win_valid ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            count        <= '0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_rnd      <= '0;
            resp_valid   <= 2'b00;
            resp_z       <= '0;
            resp_status  <= '0;
            resp_timeout <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    // win_valid already implies req_valid[win]
                    if (win_valid) begin
                        mul_a      <= win ? a1 : a0;
                        mul_b      <= win ? b1 : b0;
                        mul_rnd    <= win ? rnd1 : rnd0;
                        grant      <= win;
                        last_grant <= win;
                        mul_start  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    count <= count + 1'b1;
                    if (mul_done) begin
                        resp_z       <= mul_z;
                        resp_status  <= mul_status;
                        resp_timeout <= 1'b0;
                        resp_valid   <= grant ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        resp_z       <= '0;
                        resp_status  <= '0;
                        resp_timeout <= 1'b1;
                        resp_valid   <= grant ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[grant]) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter: a datapath stub answers from a table of
// hand-computed products, and a scoreboard monitor checks every response in order.
module tb_fp_mult_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  rnd0, rnd1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_z;
    logic [7:0]  resp_status;
    logic        resp_timeout;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic [2:0]  mul_rnd;
    logic        mul_done;
    logic [31:0] mul_z;
    logic [7:0]  mul_status;
    logic        busy;

    fp_mult_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .a0(a0), .b0(b0), .rnd0(rnd0),
        .a1(a1), .b1(b1), .rnd1(rnd1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_z(resp_z), .resp_status(resp_status), .resp_timeout(resp_timeout),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
        .mul_done(mul_done), .mul_z(mul_z), .mul_status(mul_status),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] z;
        logic [7:0]  st;
        logic        to;
    } exp_t;

    vec_t vt [0:7];
    exp_t expq [$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   stub_lat = 1;

    initial begin
        vt[0] = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00}; // 1.5*2
        vt[1] = '{32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 8'h00}; // 2*3
        vt[2] = '{32'h3F800000, 32'h3F800000, 3'd1, 32'h3F800000, 8'h00}; // 1*1
        vt[3] = '{32'hC0000000, 32'h40800000, 3'd2, 32'hC1000000, 8'h00}; // -2*4
        vt[4] = '{32'h3F000000, 32'h3F000000, 3'd3, 32'h3E800000, 8'h00}; // .5*.5
        vt[5] = '{32'h40A00000, 32'h40000000, 3'd4, 32'h41200000, 8'h00}; // 5*2
        vt[6] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h01}; // inf*0
        vt[7] = '{32'h3DCCCCCD, 32'h41200000, 3'd0, 32'h3F800000, 8'h10}; // 0.1*10
    end

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] need);
        n_vec++;
        if (got !== need) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, need);
        end
    endtask

    function automatic void push_ok(input int r, input int vi);
        exp_t e;
        e.who = (r == 0) ? 2'b01 : 2'b10;
        e.z   = vt[vi].z;
        e.st  = vt[vi].st;
        e.to  = 1'b0;
        expq.push_back(e);
    endfunction

    function automatic void push_to(input int r);
        exp_t e;
        e.who = (r == 0) ? 2'b01 : 2'b10;
        e.z   = 32'h0;
        e.st  = 8'h0;
        e.to  = 1'b1;
        expq.push_back(e);
    endfunction

    // Datapath stub: answers stub_lat cycles after the start pulse (0 = never).
    initial begin : stub
        int lat;
        logic [31:0] z;
        logic [7:0]  st;
        mul_done = 1'b0; mul_z = '0; mul_status = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                lat = stub_lat;
                if (lat > 0) begin
                    repeat (lat) @(negedge clk);
                    z = 32'hDEADBEEF; st = 8'hEE;
                    for (int i = 0; i < 8; i++)
                        if (vt[i].a == mul_a && vt[i].b == mul_b && vt[i].rnd == mul_rnd) begin
                            z = vt[i].z; st = vt[i].st;
                        end
                    mul_done = 1'b1; mul_z = z; mul_status = st;
                    @(negedge clk);
                    mul_done = 1'b0; mul_z = 32'hBAD0BAD0; mul_status = 8'h5A;
                end
            end
        end
    end

    // Scoreboard monitor: one comparison per response, on its first visible cycle.
    initial begin : monitor
        logic seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (resp_valid == 2'b00) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (expq.size() == 0)
                    check("unexpected_resp", {resp_valid, resp_z, resp_status, resp_timeout}, 75'h0);
                else begin
                    e = expq.pop_front();
                    check("resp", {resp_valid, resp_z, resp_status, resp_timeout},
                          {e.who, e.z, e.st, e.to});
                    $display("resp: valid=%b z=%h status=%h timeout=%b", resp_valid, resp_z,
                             resp_status, resp_timeout);
                end
            end
        end
    end

    task automatic send(input int r, input int vi);
        int n;
        n = 0;
        @(negedge clk);
        if (r == 0) begin a0 = vt[vi].a; b0 = vt[vi].b; rnd0 = vt[vi].rnd; end
        else        begin a1 = vt[vi].a; b1 = vt[vi].b; rnd1 = vt[vi].rnd; end
        req_valid[r] = 1'b1;
        #1;
        while (!req_ready[r]) begin
            @(negedge clk); #1;
            n++;
            if (n > 300) begin
                check("accept_timeout", 96'd0, 96'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (n >= 300) check("drain_timeout", 96'd1, 96'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
        a0 = '0; b0 = '0; rnd0 = '0; a1 = '0; b1 = '0; rnd1 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {busy, mul_start, resp_valid, resp_timeout, mul_rnd, resp_status, req_ready},
              '0);
        rst_n = 1'b1;

        // Contention straight after reset: requester 0 first, then 1.
        push_ok(0, 0); push_ok(1, 4);
        stub_lat = 2;
        fork
            send(0, 0);
            send(1, 4);
            begin @(negedge clk); #2; check("contention_ready", req_ready, 2'b01); end
        join
        drain();

        // Fairness: both continuously valid, grants alternate 0,1,0,1,0,1.
        stub_lat = 1;
        push_ok(0, 5); push_ok(1, 1); push_ok(0, 6); push_ok(1, 2); push_ok(0, 7); push_ok(1, 3);
        fork
            begin send(0, 5); send(0, 6); send(0, 7); end
            begin send(1, 1); send(1, 2); send(1, 3); end
        join
        drain();

        // Single request with latency 3: start pulse, operands, response 4 cycles later.
        stub_lat = 3;
        push_ok(0, 0);
        send(0, 0);
        @(negedge clk); #2;
        check("issue", {mul_start, mul_a, mul_b, mul_rnd}, {1'b1, 32'h3FC00000, 32'h40000000, 3'd0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #2;
            check("latency", {resp_valid, mul_start, mul_a},
                  {(k == 4) ? 2'b01 : 2'b00, 1'b0, 32'h3FC00000});
        end
        drain();

        // Timeout boundaries with TIMEOUT=16.
        stub_lat = 0;  push_to(0);    send(0, 2); drain();
        stub_lat = 16; push_ok(1, 3); send(1, 3); drain();
        stub_lat = 17; push_to(0);    send(0, 4); drain();
        repeat (4) @(negedge clk);

        // Backpressure: response held 5 cycles while requester 1 waits.
        stub_lat = 2;
        resp_ready = 2'b10;
        push_ok(0, 0); push_ok(1, 1);
        fork
            begin send(0, 0); send(1, 1); end
            begin
                n = 0;
                do begin @(negedge clk); #2; n++; end while (resp_valid == 2'b00 && n < 100);
                for (int i = 0; i < 5; i++) begin
                    check("backpressure_hold", {resp_valid, resp_z, resp_status, resp_timeout, req_ready, busy},
                          {2'b01, 32'h40400000, 8'h00, 1'b0, 2'b00, 1'b1});
                    @(negedge clk); #2;
                end
                resp_ready = 2'b11;
                @(negedge clk); #2;
                check("after_handshake_ready", {req_ready, busy}, {2'b10, 1'b0});
            end
        join
        drain();

        // Asynchronous reset mid-operation; late done pulse must be ignored.
        stub_lat = 10;
        send(0, 5);
        repeat (3) @(negedge clk);
        #2; rst_n = 1'b0; #1;
        check("async_reset_ctrl", {busy, mul_start, resp_valid, resp_timeout, mul_rnd, resp_status}, '0);
        check("async_reset_data", {mul_a, mul_b, resp_z}, '0);
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        check("stray_done_ignored", {busy, resp_valid}, 3'b000);

        // After reset, contention goes to requester 0 again.
        stub_lat = 1;
        push_ok(0, 6); push_ok(1, 7);
        fork
            send(0, 6);
            send(1, 7);
            begin @(negedge clk); #2; check("post_reset_contention", req_ready, 2'b01); end
        join
        drain();

        check("leftover_expected", 96'(expq.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
